// File: rtl/memory_arbiter_pkg.sv
// Shared types for the cache-to-RAM arbitration path.
package memory_arbiter_pkg;

    typedef logic [31:0] word_t;

    // RAM handshake state as reported by the RAM model/controller.
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        RESP    = 2'd3
    } arb_state_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// Cache-side bus: icache/dcache word requests and their wait/load responses.
interface memory_arbiter_if;
    import memory_arbiter_pkg::*;

    logic  iREN;
    word_t iaddr;
    logic  iwait;
    word_t iload;
    logic  dREN;
    logic  dWEN;
    word_t daddr;
    word_t dstore;
    logic  dwait;
    word_t dload;

    // Caches issue requests and consume responses.
    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore,
        input  iwait, iload, dwait, dload
    );

    // Arbiter consumes requests and drives responses.
    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore,
        output iwait, iload, dwait, dload
    );

endinterface

// File: rtl/memory_arbiter.sv
// Arbitrates icache/dcache word requests onto a single-ported RAM, one
// transaction at a time, data first with alternation under contention.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int unsigned RETRY_MAX = 16,
    parameter int unsigned CNT_W     = 5
) (
    input  logic            CLK,
    input  logic            RST,
    memory_arbiter_if.slave cif,
    output logic            ramREN,
    output logic            ramWEN,
    output word_t           ramaddr,
    output word_t           ramstore,
    input  word_t           ramload,
    input  ramstate_t       ramstate,
    output logic            err
);

    localparam logic [CNT_W-1:0] RETRY_LIM = CNT_W'(RETRY_MAX);

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_d_q, last_d_d;
    logic             err_q, err_d;
    logic             ren_q, ren_d;
    logic             wen_q, wen_d;
    word_t            addr_q, addr_d;
    word_t            store_q, store_d;
    word_t            iload_q, iload_d;
    word_t            dload_q, dload_d;
    logic             side_d_q, side_d_d;   // granted side is data
    logic             wr_q, wr_d;           // granted transaction is a write
    logic             abort_q, abort_d;     // requester let go before RESP

    logic             d_req;
    logic             cur_req;
    logic             strobe_on;
    logic [CNT_W-1:0] cnt_inc;

    assign d_req     = cif.dREN | cif.dWEN;
    assign cur_req   = side_d_q ? d_req : cif.iREN;
    assign strobe_on = ren_q | wen_q;
    assign cnt_inc   = cnt_q + CNT_W'(1);

    // State and datapath registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last_d_q <= 1'b0;
            err_q    <= 1'b0;
            ren_q    <= 1'b0;
            wen_q    <= 1'b0;
            addr_q   <= '0;
            store_q  <= '0;
            iload_q  <= '0;
            dload_q  <= '0;
            side_d_q <= 1'b0;
            wr_q     <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_d_q <= last_d_d;
            err_q    <= err_d;
            ren_q    <= ren_d;
            wen_q    <= wen_d;
            addr_q   <= addr_d;
            store_q  <= store_d;
            iload_q  <= iload_d;
            dload_q  <= dload_d;
            side_d_q <= side_d_d;
            wr_q     <= wr_d;
            abort_q  <= abort_d;
        end
    end

    // Next state: grant selection, RAM handshake, retry accounting.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d_d = last_d_q;
        err_d    = err_q;
        ren_d    = ren_q;
        wen_d    = wen_q;
        addr_d   = addr_q;
        store_d  = store_q;
        iload_d  = iload_q;
        dload_d  = dload_q;
        side_d_d = side_d_q;
        wr_d     = wr_q;
        abort_d  = abort_q;
        unique case (state_q)
            IDLE: begin
                cnt_d   = '0;
                abort_d = 1'b0;
                if (d_req && !(last_d_q && cif.iREN)) begin
                    state_d  = GRANT_D;
                    side_d_d = 1'b1;
                    wr_d     = cif.dWEN;
                    ren_d    = !cif.dWEN;
                    wen_d    = cif.dWEN;
                    addr_d   = cif.daddr;
                    store_d  = cif.dstore;
                end else if (cif.iREN) begin
                    state_d  = GRANT_I;
                    side_d_d = 1'b0;
                    wr_d     = 1'b0;
                    ren_d    = 1'b1;
                    wen_d    = 1'b0;
                    addr_d   = cif.iaddr;
                end
            end
            GRANT_I, GRANT_D: begin
                abort_d = abort_q | !cur_req;
                if (!strobe_on) begin
                    // Strobes were dropped for one cycle after ERROR: reissue.
                    ren_d = !wr_q;
                    wen_d = wr_q;
                end else begin
                    unique case (ramstate)
                        ACCESS: begin
                            ren_d    = 1'b0;
                            wen_d    = 1'b0;
                            last_d_d = side_d_q;
                            state_d  = RESP;
                            if (!wr_q) begin
                                if (side_d_q) dload_d = ramload;
                                else          iload_d = ramload;
                            end
                        end
                        ERROR: begin
                            ren_d = 1'b0;
                            wen_d = 1'b0;
                            cnt_d = cnt_inc;
                            if (cnt_inc == RETRY_LIM) begin
                                err_d   = 1'b1;
                                cnt_d   = '0;
                                state_d = IDLE;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            RESP: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: one-cycle wait pulse for the granted, non-aborted side.
    always_comb begin
        cif.iwait = !((state_q == RESP) && !side_d_q && !abort_q);
        cif.dwait = !((state_q == RESP) &&  side_d_q && !abort_q);
        cif.iload = iload_q;
        cif.dload = dload_q;
        ramREN    = ren_q;
        ramWEN    = wen_q;
        ramaddr   = addr_q;
        ramstore  = store_q;
        err       = err_q;
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: behavioural RAM responder,
// response scoreboard, vector table and hand-written corner sequences.
module tb_memory_arbiter;
    import memory_arbiter_pkg::*;

    logic      CLK = 1'b0;
    logic      RST;
    logic      ramREN, ramWEN, err;
    word_t     ramaddr, ramstore, ramload;
    ramstate_t ramstate;

    memory_arbiter_if cif();

    memory_arbiter #(.RETRY_MAX(16), .CNT_W(5)) dut (
        .CLK(CLK), .RST(RST), .cif(cif),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .err(err)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic  side_d;
        logic  chk_data;
        word_t data;
    } exp_t;

    typedef struct {
        logic        side_d;
        logic        wr;
        word_t       addr;
        word_t       wdata;
        int unsigned lat;
        int unsigned nerr;
        word_t       exp;
    } vec_t;

    exp_t        exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned ram_lat  = 1;
    int unsigned err_target = 0;
    int unsigned err_total  = 0;
    int unsigned acc_cnt    = 0;
    logic        err_exp    = 1'b0;
    logic        alt_on     = 1'b0;
    logic        last_resp_d = 1'b0;
    word_t       mem [word_t];

    task automatic chk(input string nm, input word_t act, input word_t exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    function automatic word_t rd(input word_t a);
        return mem.exists(a) ? mem[a] : ~a;
    endfunction

    // RAM responder: BUSY until ram_lat cycles of strobe, then ERROR/ACCESS.
    initial begin
        int unsigned wcnt;
        mem[32'h0000_0100] = 32'hDEAD_BEEF;
        mem[32'h0000_0040] = 32'h1111_2222;
        mem[32'h0000_0000] = 32'h0BAD_F00D;
        wcnt = 0; ramstate = FREE; ramload = '0;
        forever begin
            @(negedge CLK);
            if (ramREN === 1'b1 || ramWEN === 1'b1) begin
                wcnt++;
                if (wcnt >= ram_lat) begin
                    if (err_total < err_target) begin
                        ramstate = ERROR;
                        err_total++;
                    end else begin
                        ramstate = ACCESS;
                        acc_cnt++;
                        if (ramWEN === 1'b1) mem[ramaddr] = ramstore;
                        else                 ramload = rd(ramaddr);
                    end
                end else begin
                    ramstate = BUSY;
                end
            end else begin
                wcnt = 0; ramstate = FREE; ramload = '0;
            end
        end
    end

    // Response monitor: pops the scoreboard on each wait pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (cif.iwait === 1'b0 || cif.dwait === 1'b0) begin
                chk("one_side_resp", word_t'(cif.iwait | cif.dwait), 32'd1);
                chk("resp_expected", word_t'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("resp_side", word_t'(cif.dwait === 1'b0), word_t'(e.side_d));
                    if (e.chk_data)
                        chk("resp_data", e.side_d ? cif.dload : cif.iload, e.data);
                end
                if (alt_on && cif.dwait === 1'b0)
                    chk("no_dd_while_i", word_t'(last_resp_d & cif.iREN), 32'd0);
                last_resp_d = (cif.dwait === 1'b0);
            end
        end
    end

    task automatic wait_low(input logic side_d, input int unsigned budget, output logic ok);
        ok = 1'b0;
        for (int unsigned n = 0; n < budget && !ok; n++) begin
            @(negedge CLK);
            if ((side_d ? cif.dwait : cif.iwait) === 1'b0) ok = 1'b1;
        end
    endtask

    // One transaction from a vector record; starts and ends on a negedge.
    task automatic run_vec(input int idx, input vec_t v);
        int unsigned k, gaps;
        logic done, w;
        ram_lat    = v.lat;
        err_target = err_total + v.nerr;
        if (v.side_d) begin
            cif.dREN = 1'b1; cif.dWEN = v.wr; cif.daddr = v.addr; cif.dstore = v.wdata;
        end else begin
            cif.iREN = 1'b1; cif.iaddr = v.addr;
        end
        exp_q.push_back('{side_d: v.side_d, chk_data: !v.wr, data: v.exp});
        k = 0; gaps = 0; done = 1'b0; w = 1'b1;
        while (!done && k < 200) begin
            @(negedge CLK);
            k++;
            w = v.side_d ? cif.dwait : cif.iwait;
            if (k == 1) begin
                chk($sformatf("v%0d_ramREN", idx), word_t'(ramREN), word_t'(!v.wr));
                chk($sformatf("v%0d_ramWEN", idx), word_t'(ramWEN), word_t'(v.wr));
                chk($sformatf("v%0d_ramaddr", idx), ramaddr, v.addr);
                if (v.wr) chk($sformatf("v%0d_ramstore", idx), ramstore, v.wdata);
                chk($sformatf("v%0d_other_wait", idx),
                    word_t'(v.side_d ? cif.iwait : cif.dwait), 32'd1);
            end
            if (w === 1'b0) done = 1'b1;
            else if (!(ramREN | ramWEN)) gaps++;
        end
        cif.iREN = 1'b0; cif.dREN = 1'b0; cif.dWEN = 1'b0;
        chk($sformatf("v%0d_done", idx), word_t'(done), 32'd1);
        chk($sformatf("v%0d_latency", idx), word_t'(k), word_t'((v.nerr + 1) * (v.lat + 1)));
        chk($sformatf("v%0d_retry_gaps", idx), word_t'(gaps), word_t'(v.nerr));
        chk($sformatf("v%0d_err", idx), word_t'(err), word_t'(err_exp));
        @(negedge CLK);
        chk($sformatf("v%0d_wait_one_cycle", idx),
            word_t'(v.side_d ? cif.dwait : cif.iwait), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        logic ok;
        int unsigned n, lows, a0;
        word_t ia[2];
        word_t da[3];

        vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,          2, 0, 32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0200, 32'h1234_5678, 1, 0, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0,          1, 0, 32'h1234_5678};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0,          3, 3, 32'h1234_5678};
        vecs[4] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 32'hCAFE_F00D, 2, 1, 32'h0};
        vecs[5] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,          1, 0, 32'hCAFE_F00D};
        vecs[6] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,          4, 0, 32'h0BAD_F00D};
        vecs[7] = '{1'b0, 1'b0, 32'h0000_0200, 32'h0,          1, 0, 32'h1234_5678};

        // Reset held two cycles with an instruction request pending.
        RST = 1'b1;
        cif.iREN = 1'b1; cif.iaddr = 32'h0000_0040;
        cif.dREN = 1'b0; cif.dWEN = 1'b0; cif.daddr = '0; cif.dstore = '0;
        @(negedge CLK);
        chk("rst_ramREN", word_t'(ramREN), 32'd0);
        chk("rst_ramWEN", word_t'(ramWEN), 32'd0);
        chk("rst_iwait", word_t'(cif.iwait), 32'd1);
        chk("rst_dwait", word_t'(cif.dwait), 32'd1);
        chk("rst_err", word_t'(err), 32'd0);
        chk("rst_ramaddr", ramaddr, 32'h0);
        chk("rst_ramstore", ramstore, 32'h0);
        chk("rst_iload", cif.iload, 32'h0);
        chk("rst_dload", cif.dload, 32'h0);
        @(negedge CLK);
        chk("rst2_ramREN", word_t'(ramREN), 32'd0);
        chk("rst2_iwait", word_t'(cif.iwait), 32'd1);
        chk("rst2_err", word_t'(err), 32'd0);
        exp_q.push_back('{side_d: 1'b0, chk_data: 1'b1, data: 32'h1111_2222});
        RST = 1'b0;
        @(negedge CLK);
        chk("post_rst_grant_i", word_t'(ramREN), 32'd1);
        chk("post_rst_ramaddr", ramaddr, 32'h0000_0040);
        wait_low(1'b0, 50, ok);
        chk("post_rst_resp", word_t'(ok), 32'd1);
        cif.iREN = 1'b0;
        @(negedge CLK);

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Contention: both sides held, strict alternation starting with data.
        ram_lat = 1; err_target = err_total;
        ia[0] = 32'h0000_0100; ia[1] = 32'h0000_0040;
        da[0] = 32'h0000_0000; da[1] = 32'h0000_0200; da[2] = 32'h0000_0010;
        exp_q.push_back('{side_d: 1'b1, chk_data: 1'b1, data: 32'h0BAD_F00D});
        exp_q.push_back('{side_d: 1'b0, chk_data: 1'b1, data: 32'hDEAD_BEEF});
        exp_q.push_back('{side_d: 1'b1, chk_data: 1'b1, data: 32'h1234_5678});
        exp_q.push_back('{side_d: 1'b0, chk_data: 1'b1, data: 32'h1111_2222});
        exp_q.push_back('{side_d: 1'b1, chk_data: 1'b1, data: 32'hFFFF_FFEF});
        alt_on = 1'b1;
        fork
            begin
                logic okI;
                for (int i = 0; i < 2; i++) begin
                    cif.iREN = 1'b1; cif.iaddr = ia[i];
                    wait_low(1'b0, 100, okI);
                    chk("cont_i_done", word_t'(okI), 32'd1);
                end
                cif.iREN = 1'b0;
            end
            begin
                logic okD;
                for (int j = 0; j < 3; j++) begin
                    cif.dREN = 1'b1; cif.dWEN = 1'b0; cif.daddr = da[j];
                    wait_low(1'b1, 100, okD);
                    chk("cont_d_done", word_t'(okD), 32'd1);
                end
                cif.dREN = 1'b0;
            end
        join
        alt_on = 1'b0;
        @(negedge CLK);
        chk("cont_scoreboard_empty", word_t'(exp_q.size()), 32'd0);

        // Retry limit: sixteen ERRORs raise err and drop the request.
        ram_lat = 1; err_target = err_total + 16;
        cif.dREN = 1'b1; cif.dWEN = 1'b0; cif.daddr = 32'h0000_0000;
        n = 0;
        while (err !== 1'b1 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        cif.dREN = 1'b0;
        chk("err16_raised", word_t'(err), 32'd1);
        chk("err16_cycles", word_t'(n), 32'd32);
        err_target = err_total;
        err_exp = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            chk("err16_sticky", word_t'(err), 32'd1);
            chk("err16_idle_strobe", word_t'(ramREN | ramWEN), 32'd0);
            chk("err16_no_dwait", word_t'(cif.dwait), 32'd1);
        end

        // Abort: instruction request dropped while granted.
        ram_lat = 3; a0 = acc_cnt;
        cif.iREN = 1'b1; cif.iaddr = 32'h0000_0300;
        @(negedge CLK);
        chk("abort_granted", word_t'(ramREN), 32'd1);
        cif.iREN = 1'b0;
        lows = 0;
        repeat (8) begin
            @(negedge CLK);
            if (cif.iwait !== 1'b1) lows++;
        end
        chk("abort_access_done", word_t'(acc_cnt - a0), 32'd1);
        chk("abort_no_iwait", word_t'(lows), 32'd0);
        chk("abort_back_idle", word_t'(ramREN | ramWEN), 32'd0);
        run_vec(8, '{1'b1, 1'b0, 32'h0000_0200, 32'h0, 1, 0, 32'h1234_5678});

        // Reset while data is granted: transaction abandoned, err cleared.
        ram_lat = 5;
        cif.dREN = 1'b1; cif.dWEN = 1'b0; cif.daddr = 32'h0000_0000;
        @(negedge CLK);
        chk("rstd_granted", word_t'(ramREN), 32'd1);
        RST = 1'b1;
        @(negedge CLK);
        chk("rstd_strobes", word_t'(ramREN | ramWEN), 32'd0);
        chk("rstd_dwait", word_t'(cif.dwait), 32'd1);
        chk("rstd_err_clear", word_t'(err), 32'd0);
        RST = 1'b0; cif.dREN = 1'b0;
        repeat (6) begin
            @(negedge CLK);
            chk("rstd_no_dwait", word_t'(cif.dwait), 32'd1);
        end
        chk("final_scoreboard_empty", word_t'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
